instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 192 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs symbolic MIPS-subset instruction requests into 32-bit words and queues
// them, tagged with a sequential word address, in a 2-entry output buffer.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [7:0]        err_count
);

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;

    // Result bit 32 flags a legal class; fields a class does not use never reach the word.
    function automatic logic [32:0] encode_word(
        input logic [3:0]  cls,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [32:0] res;
        res = 33'd0;
        case (cls)
            4'd0:    res = {1'b1, 32'd0};
            4'd1:    res = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
            4'd2:    res = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
            4'd3:    res = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND};
            4'd4:    res = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
            4'd5:    res = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
            4'd6:    res = {1'b1, OP_ADDI, rs, rt, imm};
            4'd7:    res = {1'b1, OP_LW, rs, rt, imm};
            4'd8:    res = {1'b1, OP_SW, rs, rt, imm};
            4'd9:    res = {1'b1, OP_BEQ, rs, rt, imm};
            4'd10:   res = {1'b1, OP_J, target};
            default: res = {1'b0, 32'd0};
        endcase
        return res;
    endfunction

    logic [32:0]       enc_s;
    logic              push_s;
    logic              pop_s;
    logic              wr_s;
    logic              bad_s;
    logic [1:0]        count_nxt_s;
    logic              head_new_s;
    logic              head_shift_s;
    logic              tail_new_s;

    logic [1:0]        count_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [31:0]       head_instr_r;
    logic [ADDR_W-1:0] head_addr_r;
    logic [31:0]       tail_instr_r;
    logic [ADDR_W-1:0] tail_addr_r;
    logic [ADDR_W-1:0] addr_r;
    logic              err_illegal_r;
    logic [7:0]        err_count_r;

    assign enc_s  = encode_word(in_class, in_rs, in_rt, in_rd, in_imm, in_target);
    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;
    assign wr_s   = push_s & enc_s[32];
    assign bad_s  = push_s & ~enc_s[32];

    // Next buffer occupancy and which buffer slots load this cycle.
    always_comb begin
        count_nxt_s  = count_r;
        head_new_s   = 1'b0;
        head_shift_s = 1'b0;
        tail_new_s   = 1'b0;
        case (count_r)
            2'd0: begin
                if (wr_s) begin
                    count_nxt_s = 2'd1;
                    head_new_s  = 1'b1;
                end else begin
                    count_nxt_s = 2'd0;
                end
            end
            2'd1: begin
                if (wr_s && pop_s) begin
                    count_nxt_s = 2'd1;
                    head_new_s  = 1'b1;
                end else if (wr_s) begin
                    count_nxt_s = 2'd2;
                    tail_new_s  = 1'b1;
                end else if (pop_s) begin
                    count_nxt_s = 2'd0;
                end else begin
                    count_nxt_s = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    count_nxt_s  = 2'd1;
                    head_shift_s = 1'b1;
                end else begin
                    count_nxt_s = 2'd2;
                end
            end
            default: begin
                count_nxt_s = 2'd0;
            end
        endcase
    end

    // Occupancy and the handshake flags derived from it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            in_ready_r  <= (count_nxt_s != 2'd2);
            out_valid_r <= (count_nxt_s != 2'd0);
        end
    end

    // Head and tail slots of the output buffer; the head drives the outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_instr_r <= 32'd0;
            head_addr_r  <= {ADDR_W{1'b0}};
            tail_instr_r <= 32'd0;
            tail_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            if (head_new_s) begin
                head_instr_r <= enc_s[31:0];
                head_addr_r  <= addr_r;
            end else if (head_shift_s) begin
                head_instr_r <= tail_instr_r;
                head_addr_r  <= tail_addr_r;
            end
            if (tail_new_s) begin
                tail_instr_r <= enc_s[31:0];
                tail_addr_r  <= addr_r;
            end
        end
    end

    // Word address counter (wraps silently) and illegal-request reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r        <= {ADDR_W{1'b0}};
            err_illegal_r <= 1'b0;
            err_count_r   <= 8'd0;
        end else begin
            if (wr_s) begin
                addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            err_illegal_r <= bad_s;
            if (bad_s && (err_count_r != 8'd255)) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_instr   = head_instr_r;
    assign out_addr    = head_addr_r;
    assign err_illegal = err_illegal_r;
    assign err_count   = err_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_class = 4'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_target = 26'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        err_illegal;
    logic [7:0]  err_count;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [3:0]  in_class2 = 4'd1;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] out_instr2;
    logic [1:0]  out_addr2;
    logic        err_illegal2;
    logic [7:0]  err_count2;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err_illegal(err_illegal), .err_count(err_count)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_class(in_class2), .in_rs(5'd1), .in_rt(5'd2), .in_rd(5'd3),
        .in_imm(16'd0), .in_target(26'd0), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_instr(out_instr2), .out_addr(out_addr2),
        .err_illegal(err_illegal2), .err_count(err_count2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] instr;
    } ent_t;

    ent_t       exp_q[$];
    logic [7:0] m_addr;
    int         m_errcnt;
    logic       m_pulse;

    typedef struct {
        int          cls;
        int          rs;
        int          rt;
        int          rd;
        int          imm;
        int          tgt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Encoding rebuilt from field positions: op<<26 | rs<<21 | rt<<16 | rd<<11 | funct.
    function automatic logic [32:0] ref_word(input int cls, input int rs, input int rt,
                                             input int rd, input int imm, input int tgt);
        longint unsigned funct_tbl[5];
        longint unsigned op_tbl[4];
        longint unsigned w;
        funct_tbl = '{64'd32, 64'd34, 64'd36, 64'd37, 64'd42};
        op_tbl    = '{64'd8, 64'd35, 64'd43, 64'd4};
        w = 64'd0;
        if (cls == 0) begin
            return {1'b1, 32'd0};
        end else if (cls >= 1 && cls <= 5) begin
            w = longint'(rs) * 64'd2097152 + longint'(rt) * 64'd65536
              + longint'(rd) * 64'd2048 + funct_tbl[cls-1];
            return {1'b1, w[31:0]};
        end else if (cls >= 6 && cls <= 9) begin
            w = op_tbl[cls-6] * 64'd67108864 + longint'(rs) * 64'd2097152
              + longint'(rt) * 64'd65536 + longint'(imm);
            return {1'b1, w[31:0]};
        end else if (cls == 10) begin
            w = 64'd2 * 64'd67108864 + longint'(tgt);
            return {1'b1, w[31:0]};
        end
        return {1'b0, 32'd0};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_addr   = 8'd0;
        m_errcnt = 0;
        m_pulse  = 1'b0;
    endtask

    // Compare outputs with the model, then advance the model by the coming edge.
    task automatic model_step();
        logic [32:0] r;
        bit acc;
        bit pop;
        check("in_ready", {31'd0, in_ready}, (exp_q.size() < 2) ? 32'd1 : 32'd0);
        check("out_valid", {31'd0, out_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
        if (exp_q.size() > 0) begin
            check("out_instr", out_instr, exp_q[0].instr);
            check("out_addr", {24'd0, out_addr}, {24'd0, exp_q[0].addr});
        end
        check("err_illegal", {31'd0, err_illegal}, {31'd0, m_pulse});
        check("err_count", {24'd0, err_count}, 32'(m_errcnt));
        acc = in_valid && (exp_q.size() < 2);
        pop = (exp_q.size() > 0) && out_ready;
        if (pop) void'(exp_q.pop_front());
        m_pulse = 1'b0;
        if (acc) begin
            r = ref_word(int'(in_class), int'(in_rs), int'(in_rt), int'(in_rd),
                         int'(in_imm), int'(in_target));
            if (r[32]) begin
                exp_q.push_back({m_addr, r[31:0]});
                m_addr = m_addr + 8'd1;
            end else begin
                m_pulse = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int cls, input int rs, input int rt, input int rd,
                           input int imm, input int tgt);
        in_class  = 4'(cls);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_imm    = 16'(imm);
        in_target = 26'(tgt);
        in_valid  = 1'b1;
    endtask

    // Asynchronous assert mid-cycle, checks, release just after a rising edge.
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", {24'd0, out_addr}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_err_illegal", {31'd0, err_illegal}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        vecs[0]  = '{1, 1, 2, 3, 16'h1234, 26'h3ABCDEF, 32'h00221820};
        vecs[1]  = '{5, 4, 5, 6, 16'hFFFF, 26'h3FFFFFF, 32'h0085302A};
        vecs[2]  = '{6, 1, 2, 31, 16'hFFFF, 26'h0000155, 32'h2022FFFF};
        vecs[3]  = '{7, 29, 8, 5, 16'h0004, 26'h1234567, 32'h8FA80004};
        vecs[4]  = '{10, 31, 31, 31, 16'hFFFF, 26'h0000010, 32'h08000010};
        vecs[5]  = '{0, 31, 31, 31, 16'hFFFF, 26'h3FFFFFF, 32'h00000000};
        vecs[6]  = '{2, 31, 0, 17, 16'hAAAA, 26'h2AAAAAA, 32'h03E08822};
        vecs[7]  = '{3, 5, 6, 7, 16'h5555, 26'h0000001, 32'h00A63824};
        vecs[8]  = '{4, 0, 0, 0, 16'hFFFF, 26'h3FFFFFF, 32'h00000025};
        vecs[9]  = '{8, 2, 3, 31, 16'h8000, 26'h0ABCDEF, 32'hAC438000};
        vecs[10] = '{9, 1, 1, 0, 16'hFFFE, 26'h0000000, 32'h1021FFFE};
        vecs[11] = '{10, 0, 0, 0, 16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF};

        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Directed vector table, back-to-back with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_req(vecs[i].cls, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt);
            cyc();
            check("tbl_valid", {31'd0, out_valid}, 32'd1);
            check("tbl_instr", out_instr, vecs[i].exp);
            check("tbl_addr", {24'd0, out_addr}, 32'(i));
        end
        in_valid = 1'b0;
        cyc();
        cyc();

        // Backpressure: third request waits until the buffer drains.
        out_ready = 1'b0;
        set_req(1, 1, 2, 3, 0, 0);
        cyc();
        set_req(5, 4, 5, 6, 0, 0);
        cyc();
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        set_req(2, 31, 0, 17, 0, 0);
        cyc();
        check("bp_hold_instr", out_instr, 32'h00221820);
        cyc();
        check("bp_hold_instr2", out_instr, 32'h00221820);
        check("bp_hold_addr", {24'd0, out_addr}, 32'd12);
        out_ready = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Illegal class between two NOPs.
        do_reset();
        out_ready = 1'b1;
        set_req(0, 7, 9, 11, 16'h1111, 26'h2222);
        cyc();
        set_req(12, 1, 2, 3, 16'h4444, 26'h5555);
        cyc();
        check("ill_pulse_hi", {31'd0, err_illegal}, 32'd1);
        set_req(0, 31, 31, 31, 16'hFFFF, 26'h3FFFFFF);
        cyc();
        check("ill_pulse_lo", {31'd0, err_illegal}, 32'd0);
        check("ill_count", {24'd0, err_count}, 32'd1);
        check("ill_nop_addr", {24'd0, out_addr}, 32'd1);
        in_valid = 1'b0;
        cyc();

        // Saturation of the illegal counter.
        set_req(13, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc();
        in_valid = 1'b0;
        cyc();
        check("sat_count", {24'd0, err_count}, 32'd255);
        set_req(6, 3, 4, 0, 16'h0042, 0);
        cyc();
        check("sat_addr_not_advanced", {24'd0, out_addr}, 32'd2);
        in_valid = 1'b0;
        cyc();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            in_class  = 4'($urandom_range(15, 0));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            out_ready = ($urandom_range(2, 0) != 0);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();

        // Address wrap on a 2-bit counter.
        do_reset();
        in_valid2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("wrap_valid", {31'd0, out_valid2}, 32'd1);
            check("wrap_addr", {30'd0, out_addr2}, 32'(k % 4));
        end
        in_valid2 = 1'b0;

        // Asynchronous reset with two words buffered.
        do_reset();
        out_ready = 1'b0;
        set_req(1, 1, 2, 3, 0, 0);
        cyc();
        set_req(5, 4, 5, 6, 0, 0);
        cyc();
        in_valid = 1'b0;
        check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        do_reset();
        out_ready = 1'b1;
        set_req(2, 31, 0, 17, 0, 0);
        cyc();
        check("ar_post_addr", {24'd0, out_addr}, 32'd0);
        check("ar_post_instr", out_instr, 32'h03E08822);
        in_valid = 1'b0;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
